pll_lock_seq: RTL and testbench

Power-up and lock-supervision controller for the integer-N PLL datapath. It sequences the PLL's reset and enable, then counts sampled feedback-clock rising edges over fixed reference windows to declare lock. It monitors lock continuously and retries on loss of lock, up to a bounded number of attempts, before flagging failure. It sits between the system control register (start) and the PLL core.

---
 rtl/pll_ctrl_pkg.sv | 32 +++
 rtl/pll_edge_counter.sv | 65 ++++++
 rtl/pll_lock_seq.sv | 160 ++++++++++++++++
 tb/tb_pll_lock_seq.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_ctrl_pkg.sv
// Shared types for the PLL lock sequencer: FSM state encoding and lock-window bounds.
package pll_ctrl_pkg;

   localparam int unsigned CNT_W   = 16;
   localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_PRST    = 3'd1,
      ST_SETTLE  = 3'd2,
      ST_MEASURE = 3'd3,
      ST_LOCKED  = 3'd4,
      ST_FAIL    = 3'd5
   } state_t;

   typedef struct packed {
      logic [CNT_W-1:0] lo;
      logic [CNT_W-1:0] hi;
   } win_range_t;

   // Inclusive acceptance band around the expected edge count, clipped to the counter range.
   function automatic win_range_t win_range(input int unsigned exp_edges, input int unsigned tol);
      int unsigned lo;
      int unsigned hi;
      lo = (exp_edges > tol) ? exp_edges - tol : 0;
      hi = exp_edges + tol;
      if (hi > CNT_MAX) hi = CNT_MAX;
      if (lo > CNT_MAX) lo = CNT_MAX;
      return '{lo: CNT_W'(lo), hi: CNT_W'(hi)};
   endfunction

endpackage

// File: rtl/pll_edge_counter.sv
// Synchronises the PLL feedback clock, detects its rising edges and counts them
// over back-to-back windows of WIN_CYC reference cycles while run is high.
module pll_edge_counter
   import pll_ctrl_pkg::*;
#(
   parameter int unsigned WIN_CYC = 1024
) (
   input  logic             clk_in,
   input  logic             rst,
   input  logic             fb_clk,
   input  logic             run,
   output logic [CNT_W-1:0] count,
   output logic             win_done
);

   localparam int unsigned WW = $clog2(WIN_CYC);

   logic [2:0]       sync;
   logic             rise;
   logic             last;
   logic [WW-1:0]    win_cyc;
   logic [CNT_W-1:0] acc;
   logic [CNT_W-1:0] acc_next;

   // NOTE: non-blocking assignments so every flop samples pre-edge values, whatever the block order.
   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) sync <= '0;
      else     sync <= {sync[1:0], fb_clk};
   end

   // sync[1] is the synchronised level, sync[2] its previous value.
   assign rise = sync[1] & ~sync[2];
   assign last = (win_cyc == WW'(WIN_CYC - 1));

   // NOTE: default assignment first so every path drives acc_next and no latch is inferred.
   always_comb begin
      acc_next = acc;
      if (rise && (acc != '1)) acc_next = acc + 1'b1;
   end

   // An edge seen on the final cycle lands in the closing window; the next one starts from zero.
   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         win_cyc  <= '0;
         acc      <= '0;
         count    <= '0;
         win_done <= 1'b0;
      end else if (!run) begin
         win_cyc  <= '0;
         acc      <= '0;
         win_done <= 1'b0;
      end else begin
         win_done <= last;
         if (last) begin
            win_cyc <= '0;
            acc     <= '0;
            count   <= acc_next;
         end else begin
            win_cyc <= win_cyc + 1'b1;
            acc     <= acc_next;
         end
      end
   end

endmodule

// File: rtl/pll_lock_seq.sv
// PLL power-up and lock-supervision sequencer with bounded retries.
// Optional sticky lock-event interrupt when PLL_LOCK_IRQ_EN is defined.
module pll_lock_seq
   import pll_ctrl_pkg::*;
#(
   parameter int unsigned RST_CYC    = 16,
   parameter int unsigned SETTLE_CYC = 256,
   parameter int unsigned WIN_CYC    = 1024,
   parameter int unsigned EXP_EDGES  = 16,
   parameter int unsigned TOL        = 1,
   parameter int unsigned LOCK_WINS  = 4,
   parameter int unsigned MAX_RETRY  = 3
) (
   input  logic                             clk_in,
   input  logic                             rst,
   input  logic                             start,
   input  logic                             fb_clk,
`ifdef PLL_LOCK_IRQ_EN
   input  logic                             irq_clr,
   output logic                             irq,
`endif
   output logic                             pll_rst,
   output logic                             pll_enable,
   output logic                             locked,
   output logic                             lock_fail,
   output logic [$clog2(MAX_RETRY+1)-1:0]   retry_cnt,
   output logic [2:0]                       state
);

   localparam int unsigned RW      = $clog2(MAX_RETRY + 1);
   localparam int unsigned CYC_MAX = (RST_CYC > SETTLE_CYC) ? RST_CYC : SETTLE_CYC;
   localparam int unsigned CW      = $clog2(CYC_MAX + 1);
   localparam int unsigned GW      = $clog2(LOCK_WINS + 1);
   localparam int unsigned BUDGET  = 4 * LOCK_WINS;
   localparam int unsigned TW      = $clog2(BUDGET + 1);
   localparam win_range_t  RANGE   = win_range(EXP_EDGES, TOL);

   state_t           st;
   logic [CW-1:0]    cyc_cnt;
   logic [GW-1:0]    good_cnt;
   logic [TW-1:0]    win_total;
   logic [CNT_W-1:0] win_count;
   logic             win_done;
   logic             run;
   logic             in_range;
   logic             abort;

   assign run      = (st == ST_MEASURE) || (st == ST_LOCKED);
   assign in_range = (win_count >= RANGE.lo) && (win_count <= RANGE.hi);
   assign state    = st;

   pll_edge_counter #(.WIN_CYC(WIN_CYC)) u_edge_counter (
      .clk_in   (clk_in),
      .rst      (rst),
      .fb_clk   (fb_clk),
      .run      (run),
      .count    (win_count),
      .win_done (win_done)
   );

   // An attempt ends on a bad window while locked, or when the measure budget runs out unlocked.
   always_comb begin
      abort = 1'b0;
      if (win_done) begin
         if (st == ST_LOCKED)
            abort = !in_range;
         else if (st == ST_MEASURE)
            abort = !(in_range && (good_cnt == GW'(LOCK_WINS - 1))) &&
                    (win_total == TW'(BUDGET - 1));
      end
   end

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst || !start) begin
         st         <= ST_IDLE;
         pll_rst    <= 1'b1;
         pll_enable <= 1'b0;
         locked     <= 1'b0;
         lock_fail  <= 1'b0;
         retry_cnt  <= '0;
         cyc_cnt    <= '0;
         good_cnt   <= '0;
         win_total  <= '0;
      end else begin
         unique case (st)
            ST_IDLE: begin
               st      <= ST_PRST;
               cyc_cnt <= '0;
            end
            ST_PRST: begin
               if (cyc_cnt == CW'(RST_CYC - 1)) begin
                  st         <= ST_SETTLE;
                  cyc_cnt    <= '0;
                  pll_rst    <= 1'b0;
                  pll_enable <= 1'b1;
               end else begin
                  cyc_cnt <= cyc_cnt + 1'b1;
               end
            end
            ST_SETTLE: begin
               if (cyc_cnt == CW'(SETTLE_CYC - 1)) begin
                  st        <= ST_MEASURE;
                  cyc_cnt   <= '0;
                  good_cnt  <= '0;
                  win_total <= '0;
               end else begin
                  cyc_cnt <= cyc_cnt + 1'b1;
               end
            end
            ST_MEASURE: begin
               if (win_done) begin
                  win_total <= win_total + 1'b1;
                  good_cnt  <= in_range ? good_cnt + 1'b1 : '0;
                  if (in_range && (good_cnt == GW'(LOCK_WINS - 1))) begin
                     st     <= ST_LOCKED;
                     locked <= 1'b1;
                  end
               end
            end
            ST_LOCKED, ST_FAIL: ;
            default: st <= ST_IDLE;
         endcase

         if (abort) begin
            locked     <= 1'b0;
            pll_rst    <= 1'b1;
            pll_enable <= 1'b0;
            cyc_cnt    <= '0;
            if (retry_cnt < RW'(MAX_RETRY)) begin
               retry_cnt <= retry_cnt + 1'b1;
               st        <= ST_PRST;
            end else begin
               st        <= ST_FAIL;
               lock_fail <= 1'b1;
            end
         end
      end
   end

`ifdef PLL_LOCK_IRQ_EN
   state_t st_q;
   logic   irq_set;

   // Entering or leaving LOCKED, or entering FAIL; a set beats a simultaneous clear.
   assign irq_set = ((st == ST_LOCKED) != (st_q == ST_LOCKED)) ||
                    ((st == ST_FAIL) && (st_q != ST_FAIL));

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         st_q <= ST_IDLE;
         irq  <= 1'b0;
      end else begin
         st_q <= st;
         if (irq_set)      irq <= 1'b1;
         else if (irq_clr) irq <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_pll_lock_seq.sv
// Self-checking bench for pll_lock_seq: randomised feedback edge counts per window,
// checked against a window-level model of the lock/retry rules. Honours PLL_LOCK_IRQ_EN.
module tb_pll_lock_seq;

   localparam int RST    = 16;
   localparam int SETTLE = 64;
   localparam int WIN    = 256;
   localparam int EXP    = 8;
   localparam int TOL    = 1;
   localparam int LW     = 4;
   localparam int MR     = 3;
   localparam int BUDGET = 4 * LW;

   localparam int M_IDLE = 0, M_PRST = 1, M_SETTLE = 2, M_MEASURE = 3, M_LOCKED = 4, M_FAIL = 5;

   logic       clk_in = 1'b0;
   logic       rst    = 1'b1;
   logic       start  = 1'b0;
   logic       fb_clk = 1'b0;
   logic       pll_rst, pll_enable, locked, lock_fail;
   logic [1:0] retry_cnt;
   logic [2:0] state;
`ifdef PLL_LOCK_IRQ_EN
   logic       irq_clr = 1'b0;
   logic       irq;
`endif

   int checks = 0;
   int errors = 0;
   int m_st    = M_IDLE;
   int m_retry = 0;
   int m_good  = 0;
   int m_total = 0;

   pll_lock_seq #(
      .RST_CYC(RST), .SETTLE_CYC(SETTLE), .WIN_CYC(WIN), .EXP_EDGES(EXP),
      .TOL(TOL), .LOCK_WINS(LW), .MAX_RETRY(MR)
   ) dut (
      .clk_in     (clk_in),
      .rst        (rst),
      .start      (start),
      .fb_clk     (fb_clk),
`ifdef PLL_LOCK_IRQ_EN
      .irq_clr    (irq_clr),
      .irq        (irq),
`endif
      .pll_rst    (pll_rst),
      .pll_enable (pll_enable),
      .locked     (locked),
      .lock_fail  (lock_fail),
      .retry_cnt  (retry_cnt),
      .state      (state)
   );

   always #5 clk_in = ~clk_in;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic drive(input logic v);
      fb_clk = v;
      tick();
   endtask

   // All outputs follow from the state the model expects.
   task automatic chk(input string tag, input int st);
      check({tag, ".state"},      state,      st);
      check({tag, ".pll_rst"},    pll_rst,    (st == M_IDLE) || (st == M_PRST) || (st == M_FAIL));
      check({tag, ".pll_enable"}, pll_enable, (st == M_SETTLE) || (st == M_MEASURE) || (st == M_LOCKED));
      check({tag, ".locked"},     locked,     st == M_LOCKED);
      check({tag, ".lock_fail"},  lock_fail,  st == M_FAIL);
      check({tag, ".retry_cnt"},  retry_cnt,  (st == M_IDLE) ? 0 : m_retry);
   endtask

   // Entered just after the edge that put the DUT in PRST; leaves at the first MEASURE cycle.
   task automatic setup();
      m_st = M_PRST;
      chk("prst_entry", M_PRST);
      repeat (RST - 1) drive(1'b0);
      chk("prst_last", M_PRST);
      drive(1'b0);
      chk("settle_entry", M_SETTLE);
      for (int j = 0; j < SETTLE - 1; j++)
         drive((j < SETTLE / 2) ? 1'($urandom_range(1, 0)) : 1'b0);
      chk("settle_last", M_SETTLE);
      drive(1'b0);
      m_st    = M_MEASURE;
      m_good  = 0;
      m_total = 0;
      chk("measure_entry", M_MEASURE);
   endtask

   // Runs max_win windows with lo..hi feedback edges each, following retries; stops early on FAIL.
   task automatic windows(input int lo, input int hi, input int max_win, input bit settle_last);
      int done;
      int n;
      int base;
      bit pend;
      bit good;
      bit trans;
      done = 0;
      pend = 1'b0;
      while (done < max_win) begin
         n    = $urandom_range(hi, lo);
         base = 16 + $urandom_range(8, 0);
         for (int j = 0; j < WIN; j++) begin
            if (j == 1 && pend) begin
               chk("window_end", m_st);
               pend = 1'b0;
            end
            fb_clk = (j >= base) && (j < base + 20 * n) && (((j - base) % 20) < 4);
            tick();
         end
         done++;
         good  = (n >= EXP - TOL) && (n <= EXP + TOL);
         trans = 1'b0;
         if (m_st == M_LOCKED) begin
            trans = !good;
         end else begin
            m_total++;
            m_good = good ? m_good + 1 : 0;
            if (m_good == LW) m_st = M_LOCKED;
            else              trans = (m_total == BUDGET);
         end
         if (trans) begin
            if (m_retry < MR) begin
               m_retry++;
               m_st = M_PRST;
            end else begin
               m_st = M_FAIL;
            end
            drive(1'b0);
            if (m_st == M_FAIL) begin
               chk("fail_entry", M_FAIL);
               return;
            end
            if (done >= max_win) begin
               chk("retry_entry", M_PRST);
               return;
            end
            setup();
         end else if (done >= max_win) begin
            if (settle_last) begin
               drive(1'b0);
               chk("window_last", m_st);
            end
         end else begin
            pend = 1'b1;
         end
      end
   endtask

   task automatic go();
      start = 1'b1;
      tick();
      setup();
   endtask

   task automatic stop(input string tag);
      start  = 1'b0;
      fb_clk = 1'b0;
      tick();
      m_st    = M_IDLE;
      m_retry = 0;
      chk(tag, M_IDLE);
   endtask

   initial begin
      // Reset values while rst is held.
      repeat (2) @(posedge clk_in);
      #1;
      chk("reset", M_IDLE);
`ifdef PLL_LOCK_IRQ_EN
      check("reset.irq", irq, 1'b0);
`endif
      rst = 1'b0;
      tick();
      chk("idle", M_IDLE);

      // Nominal lock at the expected edge rate.
      go();
      windows(EXP, EXP, LW, 1'b1);
      check("lock.locked", locked, 1'b1);
`ifdef PLL_LOCK_IRQ_EN
      drive(1'b0);
      check("irq_on_lock", irq, 1'b1);
      irq_clr = 1'b1;
      drive(1'b0);
      check("irq_cleared", irq, 1'b0);
`endif

      // Loss of lock from a fast feedback clock: retry.
      windows(EXP + 3, EXP + 3, 1, 1'b0);
`ifdef PLL_LOCK_IRQ_EN
      drive(1'b0);
      check("irq_set_beats_clr", irq, 1'b1);
      drive(1'b0);
      check("irq_clr_after", irq, 1'b0);
      irq_clr = 1'b0;
`endif
      stop("stop_after_loss");

      // Dead feedback clock: every attempt times out, then FAIL until start drops.
      go();
      windows(0, 0, 1000, 1'b0);
      check("dead.retry_cnt", retry_cnt, MR);
      repeat (5) drive(1'b0);
      chk("fail_hold", M_FAIL);
      stop("fail_to_idle");

      // Band edges: just inside locks, just outside never does.
      go();
      windows(EXP - TOL, EXP - TOL, LW, 1'b1);
      stop("stop_lo_in");
      go();
      windows(EXP - TOL - 1, EXP - TOL - 1, LW + 2, 1'b1);
      stop("stop_lo_out");
      go();
      windows(EXP + TOL + 1, EXP + TOL + 1, LW + 2, 1'b1);
      stop("stop_hi_out");

      // start dropped exactly when the locking window is being judged: IDLE wins.
      go();
      windows(EXP + TOL, EXP + TOL, LW, 1'b0);
      stop("stop_beats_lock");

      // start dropped part-way through a measurement window.
      go();
      windows(EXP, EXP, 1, 1'b1);
      repeat (100) drive(1'b0);
      stop("stop_mid_measure");

      // Asynchronous reset while locked after one retry.
      go();
      windows(0, 0, BUDGET, 1'b0);
      setup();
      windows(EXP, EXP, LW, 1'b1);
      check("pre_rst.retry_cnt", retry_cnt, 1);
      #3 rst = 1'b1;
      #1;
      m_st    = M_IDLE;
      m_retry = 0;
      chk("async_rst", M_IDLE);
      start = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      chk("post_rst", M_IDLE);

      // Random soak around the acceptance band.
      go();
      windows(EXP - 2, EXP + 2, 30, 1'b1);
      stop("soak_stop");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
